// File: rtl/clock_pkg.sv
// Shared encodings for the clock time source: set modes, field limits and
// the per-mode blink masks used by the display side.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  localparam logic [2:0] BLINK_RUN  = 3'b000;
  localparam logic [2:0] BLINK_HOUR = 3'b100;
  localparam logic [2:0] BLINK_MIN  = 3'b010;
  localparam logic [2:0] BLINK_SEC  = 3'b001;

  function automatic logic [2:0] mode_blink(input mode_e mode);
    case (mode)
      MODE_SET_HOUR: return BLINK_HOUR;
      MODE_SET_MIN:  return BLINK_MIN;
      MODE_SET_SEC:  return BLINK_SEC;
      default:       return BLINK_RUN;
    endcase
  endfunction

  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
    return (val == max) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button to single-cycle press pulse: 2-flop synchronizer, level
// debounce on a stable-sample count, registered rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_src,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      level     <= 1'b0;
      level_q   <= 1'b0;
      cnt       <= '0;
      btn_pulse <= 1'b0;
    end else begin
      sync_1    <= btn_raw;
      sync_2    <= sync_1;
      level_q   <= level;
      btn_pulse <= level & ~level_q;
      // any sample that agrees with the accepted level restarts the count
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Running hh:mm:ss time source with MODE/INC button setting; feeds the
// displayer directly and exports the edited field for blinking.
//
// state         | meaning
// MODE_RUN      | time advances on prescaler tick, INC ignored
// MODE_SET_HOUR | clock frozen, INC bumps hour (23 -> 0)
// MODE_SET_MIN  | clock frozen, INC bumps minute (59 -> 0)
// MODE_SET_SEC  | clock frozen, INC bumps second (59 -> 0)
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int TICK_DIV        = 100000000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_src,
  input  logic             rst_n,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [WIDTH-1:0] sec_data,
  output logic [WIDTH-1:0] min_data,
  output logic [WIDTH-1:0] hour_data,
  output logic [1:0]       set_mode,
  output logic [2:0]       blink_mask
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  mode_e         state;
  logic [PW-1:0] presc;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [5:0]    hour_q;
  logic          mode_pulse;
  logic          inc_pulse;
  logic          tick;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk_src  (clk_src),
    .rst_n    (rst_n),
    .btn_raw  (btn_mode),
    .btn_pulse(mode_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .clk_src  (clk_src),
    .rst_n    (rst_n),
    .btn_raw  (btn_inc),
    .btn_pulse(inc_pulse)
  );

  assign tick = (state == MODE_RUN) && (presc == PRESC_LAST);

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MODE_RUN;
      presc  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      // leaving RUN parks the prescaler so re-entry starts a full second
      if (state != MODE_RUN || mode_pulse || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      if (tick) begin
        if (sec_q == SEC_MAX) begin
          sec_q <= '0;
          if (min_q == MIN_MAX) begin
            min_q  <= '0;
            hour_q <= wrap_inc(hour_q, HOUR_MAX);
          end else begin
            min_q <= min_q + 6'd1;
          end
        end else begin
          sec_q <= sec_q + 6'd1;
        end
      end else if (inc_pulse && !mode_pulse) begin
        case (state)
          MODE_SET_HOUR: hour_q <= wrap_inc(hour_q, HOUR_MAX);
          MODE_SET_MIN:  min_q  <= wrap_inc(min_q, MIN_MAX);
          MODE_SET_SEC:  sec_q  <= wrap_inc(sec_q, SEC_MAX);
          default:       ;
        endcase
      end

      if (mode_pulse) begin
        case (state)
          MODE_RUN:      state <= MODE_SET_HOUR;
          MODE_SET_HOUR: state <= MODE_SET_MIN;
          MODE_SET_MIN:  state <= MODE_SET_SEC;
          default:       state <= MODE_RUN;
        endcase
      end
    end
  end

  assign set_mode   = state;
  assign blink_mask = mode_blink(state);
  assign sec_data   = WIDTH'(sec_q);
  assign min_data   = WIDTH'(min_q);
  assign hour_data  = WIDTH'(hour_q);

endmodule

// File: tb/tb_clock_time_setter.sv
// Scoreboard bench for clock_time_setter: stimulus queues cycle-stamped
// expected outputs, monitors pop and compare them as the cycles arrive.
module tb_clock_time_setter;

  localparam int W  = 32;
  localparam int TD = 4;
  localparam int DC = 3;

  logic         clk_src  = 1'b0;
  logic         rst_n    = 1'b0;
  logic         btn_mode = 1'b0;
  logic         btn_inc  = 1'b0;
  logic [W-1:0] sec_data;
  logic [W-1:0] min_data;
  logic [W-1:0] hour_data;
  logic [1:0]   set_mode;
  logic [2:0]   blink_mask;

  clock_time_setter #(.WIDTH(W), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_src   (clk_src),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sec_data  (sec_data),
    .min_data  (min_data),
    .hour_data (hour_data),
    .set_mode  (set_mode),
    .blink_mask(blink_mask)
  );

  always #10 clk_src = ~clk_src;

  int cyc = 0;
  always @(posedge clk_src) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int    cyc;
    bit    imm;
    int    h;
    int    m;
    int    s;
    int    mode;
    string name;
  } exp_t;

  exp_t q[$];
  event chk_now;

  // reference model: frozen base time, plus elapsed ticks while in RUN
  int m_mode = 0;
  int b_h = 0, b_m = 0, b_s = 0;
  int ref_c = 0;
  int last_e = 0;

  function automatic logic [2:0] blink_of(input int md);
    case (md)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic compare(input exp_t e);
    logic ok;
    n_checks++;
    ok = (sec_data == W'(e.s)) && (min_data == W'(e.m)) && (hour_data == W'(e.h)) &&
         (set_mode == 2'(e.mode)) && (blink_mask == blink_of(e.mode));
    if (!ok) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d:%0d:%0d mode=%0d blink=%b, want %0d:%0d:%0d mode=%0d blink=%b",
               e.name, cyc, hour_data, min_data, sec_data, set_mode, blink_mask,
               e.h, e.m, e.s, e.mode, blink_of(e.mode));
    end
  endtask

  initial forever begin
    @(negedge clk_src);
    while (q.size() > 0 && !q[0].imm && q[0].cyc <= cyc) begin
      if (q[0].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: missed check for cyc %0d, now %0d", q[0].name, q[0].cyc, cyc);
        void'(q.pop_front());
      end else begin
        compare(q.pop_front());
      end
    end
  end

  initial forever begin
    @(chk_now);
    if (q.size() > 0 && q[0].imm) begin
      compare(q.pop_front());
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL immediate_check: no immediate entry queued, got none want 1");
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_src);
    #1;
  endtask

  task automatic time_at(input int c, output int h, output int mi, output int s);
    int t;
    t = b_h * 3600 + b_m * 60 + b_s;
    if (m_mode == 0) t += (c - ref_c) / TD;
    t  = t % 86400;
    h  = t / 3600;
    mi = (t / 60) % 60;
    s  = t % 60;
  endtask

  task automatic expect_at(input int c, input string nm);
    int h, mi, s;
    time_at(c, h, mi, s);
    q.push_back('{c, 1'b0, h, mi, s, m_mode, nm});
  endtask

  // mode advances on edge e; a tick landing on e is still applied
  task automatic mode_step(input int e);
    int h, mi, s;
    expect_at(e - 1, "pre_mode");
    time_at(e, h, mi, s);
    b_h = h; b_m = mi; b_s = s;
    m_mode = (m_mode + 1) % 4;
    if (m_mode == 0) ref_c = e;
    last_e = e;
    expect_at(e, "mode_step");
    if (m_mode == 0) begin
      expect_at(e + TD - 1, "run_pre_tick");
      expect_at(e + TD, "run_first_tick");
    end
  endtask

  task automatic inc_step(input int e);
    expect_at(e - 1, "pre_inc");
    case (m_mode)
      1: b_h = (b_h == 23) ? 0 : b_h + 1;
      2: b_m = (b_m == 59) ? 0 : b_m + 1;
      3: b_s = (b_s == 59) ? 0 : b_s + 1;
      default: ;
    endcase
    expect_at(e, (m_mode == 0) ? "inc_in_run" : "inc_step");
  endtask

  task automatic press_mode(input int hold);
    mode_step(cyc + DC + 4);
    btn_mode = 1'b1;
    step(hold);
    btn_mode = 1'b0;
    step(8);
  endtask

  task automatic press_inc();
    inc_step(cyc + DC + 4);
    btn_inc = 1'b1;
    step(4);
    btn_inc = 1'b0;
    step(8);
  endtask

  task automatic press_both();
    mode_step(cyc + DC + 4);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(4);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(8);
  endtask

  task automatic glitch_inc();
    expect_at(cyc + DC + 4, "glitch_hold");
    expect_at(cyc + DC + 7, "glitch_after");
    btn_inc = 1'b1;
    step(2);
    btn_inc = 1'b0;
    step(10);
  endtask

  initial begin
    int cr;
    q.push_back('{1, 1'b0, 0, 0, 0, 0, "reset_c1"});
    q.push_back('{2, 1'b0, 0, 0, 0, 0, "reset_c2"});
    repeat (2) @(posedge clk_src);
    @(negedge clk_src);
    #1;
    rst_n = 1'b1;
    ref_c = cyc;

    // free run: 60 edges at 4 cycles per second
    expect_at(ref_c + 3, "tick_pre");
    expect_at(ref_c + 4, "tick_first");
    expect_at(ref_c + 60, "run_60");
    step(ref_c + 61 - cyc);

    // RUN -> SET_HOUR with a long press; hour wrap then set 23
    press_mode(10);
    while (b_h != 23) press_inc();
    press_inc();
    while (b_h != 23) press_inc();
    glitch_inc();

    // SET_MIN wrap 58 -> 59 -> 0, then set 59
    press_mode(4);
    while (b_m != 58) press_inc();
    press_inc();
    press_inc();
    while (b_m != 59) press_inc();

    // coincident MODE and INC: mode advances, minute untouched
    press_both();
    while (b_s != 59) press_inc();

    // back to RUN at 23:59:59; rollover and minute carry
    press_mode(4);
    expect_at(last_e + TD + 59 * TD, "sec_59");
    expect_at(last_e + TD + 60 * TD, "min_carry");
    step(last_e + TD + 60 * TD + 2 - cyc);
    press_inc();

    // reset while MODE is held in SET_MIN
    press_mode(4);
    press_mode(4);
    btn_mode = 1'b1;
    step(3);
    #4;
    rst_n = 1'b0;
    #2;
    q.push_back('{cyc, 1'b1, 0, 0, 0, 0, "async_reset"});
    ->chk_now;
    q.push_back('{cyc, 1'b0, 0, 0, 0, 0, "reset_hold_a"});
    q.push_back('{cyc + 1, 1'b0, 0, 0, 0, 0, "reset_hold_b"});
    step(3);
    rst_n = 1'b1;
    cr = cyc;
    m_mode = 0;
    b_h = 0; b_m = 0; b_s = 0;
    ref_c = cr;
    mode_step(cr + DC + 4);
    step(10);
    btn_mode = 1'b0;
    step(12);

    while (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: check for cyc %0d never reached, now %0d", q[0].name, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(20 * 20000);
    n_errors++;
    $display("FAIL watchdog: cycle budget exhausted at cyc %0d, want finish before 20000", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
